// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered bitwise logic unit. Applies one of eight logic
// operations to two WIDTH-bit operands and queues results in a 2-entry FIFO
// with valid/ready handshakes on both sides, plus a completed-output counter.
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
    output logic             y_any,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_e;

    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             emit;

    // Ready depends only on registered occupancy (and reset), never on out_ready.
    assign in_ready  = (occ_q != OCC_FULL) && !rst;
    assign out_valid = (occ_q != OCC_EMPTY);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    assign y     = head_q;
    assign y_all = &head_q;
    assign y_any = |head_q;
    assign count = count_q;

    // Bitwise operation selected by op on the operands presented this cycle.
    always_comb begin
        result = '0;
        case (op)
            3'd0:    result = a & b;
            3'd1:    result = a | b;
            3'd2:    result = a ^ b;
            3'd3:    result = ~(a & b);
            3'd4:    result = ~(a | b);
            3'd5:    result = ~(a ^ b);
            3'd6:    result = ~a;
            default: result = a;
        endcase
    end

    // FIFO occupancy, head/tail entries and handshake counter next state.
    // The head register keeps its value when the buffer drains, so y holds
    // the last result while empty.
    always_comb begin
        occ_d   = occ_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = emit ? count_q + CNT_W'(1) : count_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    head_d = result;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && emit) begin
                    head_d = result;
                end else if (accept) begin
                    tail_d = result;
                    occ_d  = OCC_FULL;
                end else if (emit) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (emit) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // State registers with asynchronous reset discarding all buffered data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Testbench for logic_gate_unit: directed vector table, back-pressure,
// reset and counter-wrap sequences, plus a randomized stream checked
// against a truth-table reference model and a result queue.
module tb_logic_gate_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready_w;
    logic [7:0]  a, b;
    logic [2:0]  op;
    logic        out_valid, out_valid_w;
    logic        out_ready;
    logic [7:0]  y, y_w;
    logic        y_all, y_all_w, y_any, y_any_w;
    logic [15:0] count;
    logic [3:0]  count_w;

    int vectors;
    int miscompares;

    logic_gate_unit #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_all(y_all), .y_any(y_any), .count(count)
    );

    logic_gate_unit #(.WIDTH(8), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .op(op), .out_valid(out_valid_w), .out_ready(out_ready),
        .y(y_w), .y_all(y_all_w), .y_any(y_any_w), .count(count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       all;
        logic       any;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each op is a 2-input truth table indexed by {a_i, b_i}.
    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        logic [3:0] tt [8];
        logic [7:0] r;
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
        tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
        for (int i = 0; i < 8; i++) r[i] = tt[o][{x[i], z[i]}];
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_y", {y, y_all, y_any}, 0);
        chk("rst_count", count, 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t tbl [10];
        logic [7:0] q [$];
        logic [7:0] exp;
        int sent, got, cyc;
        logic acc, emt;

        vectors = 0;
        miscompares = 0;
        rst = 1'b1;

        tbl[0] = '{3'd0, 8'hCA, 8'h5F, 8'h4A, 1'b0, 1'b1};
        tbl[1] = '{3'd1, 8'hCA, 8'h5F, 8'hDF, 1'b0, 1'b1};
        tbl[2] = '{3'd2, 8'hCA, 8'h5F, 8'h95, 1'b0, 1'b1};
        tbl[3] = '{3'd3, 8'hCA, 8'h5F, 8'hB5, 1'b0, 1'b1};
        tbl[4] = '{3'd4, 8'hCA, 8'h5F, 8'h20, 1'b0, 1'b1};
        tbl[5] = '{3'd5, 8'hCA, 8'h5F, 8'h6A, 1'b0, 1'b1};
        tbl[6] = '{3'd6, 8'hCA, 8'h5F, 8'h35, 1'b0, 1'b1};
        tbl[7] = '{3'd7, 8'hCA, 8'h5F, 8'hCA, 1'b0, 1'b1};
        tbl[8] = '{3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1};
        tbl[9] = '{3'd0, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0};

        do_reset();

        // Op sweep and reductions, one cycle latency each
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            op = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
            #1;
            chk("tbl_in_ready", in_ready, 1);
            tick();
            chk("tbl_out_valid", out_valid, 1);
            chk("tbl_y", y, tbl[i].y);
            chk("tbl_y_all", y_all, tbl[i].all);
            chk("tbl_y_any", y_any, tbl[i].any);
            if (i == 7) begin
                in_valid = 1'b0;
                tick();
                chk("sweep_count", count, 8);
                chk("sweep_drained", out_valid, 0);
                chk("empty_holds_y", y, 8'hCA);
            end
        end
        in_valid = 1'b0;
        tick();

        // Back-pressure: four offers, only two accepted
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; out_ready = 1'b0; op = 3'd1; b = 8'h00;
            a = 8'(1 << k);
            #1;
            chk("bp_in_ready", in_ready, (k < 2) ? 1 : 0);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_head0", {out_valid, y}, {1'b1, 8'h01});
        out_ready = 1'b1;
        tick();
        chk("bp_head1", {out_valid, y}, {1'b1, 8'h02});
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_empty", out_valid, 0);
        chk("bp_count", count, 12);

        // Randomized stream against the reference queue
        do_reset();
        q.delete();
        sent = 0; got = 0; cyc = 0;
        while (got < 100 && cyc < 3000) begin
            in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            #1;
            chk("rnd_out_valid", out_valid, (q.size() > 0) ? 1 : 0);
            chk("rnd_in_ready", in_ready, (q.size() < 2) ? 1 : 0);
            acc = in_valid && (q.size() < 2);
            emt = out_ready && (q.size() > 0);
            if (emt) begin
                exp = q.pop_front();
                chk("rnd_y", y, exp);
                chk("rnd_red", {y_all, y_any}, {exp == 8'hFF, exp != 8'h00});
                chk("rnd_y_w", {y_w, y_all_w, y_any_w}, {exp, exp == 8'hFF, exp != 8'h00});
                got++;
            end
            if (acc) begin
                q.push_back(ref_op(op, a, b));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        if (got < 100) begin
            miscompares++;
            $display("FAIL rnd_timeout: got %0d results expected 100", got);
        end
        chk("rnd_count", count, 100);
        chk("rnd_count_w", count_w, 100 % 16);
        chk("rnd_out_valid_w", out_valid_w, (q.size() > 0) ? 1 : 0);

        // Reset mid-operation with a full buffer
        out_ready = 1'b1;
        tick(); tick(); tick();
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd7; a = 8'hAA;
        tick();
        a = 8'h55;
        tick();
        in_valid = 1'b0;
        chk("mid_full", {out_valid, in_ready, y}, {1'b1, 1'b0, 8'hAA});
        #2;
        rst = 1'b1;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_y", {y, y_all, y_any}, 0);
        chk("mid_count", count, 0);
        chk("mid_in_ready", in_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_release_ready", in_ready, 1);
        in_valid = 1'b1; out_ready = 1'b1; a = 8'h3C; op = 3'd7;
        tick();
        in_valid = 1'b0;
        chk("mid_first", {out_valid, y}, {1'b1, 8'h3C});
        tick();
        chk("mid_count1", count, 1);
        chk("mid_empty", out_valid, 0);

        // Counter wrap on the CNT_W=4 instance
        do_reset();
        for (int i = 0; i < 18; i++) begin
            in_valid = (i < 17); out_ready = 1'b1; op = 3'd2;
            a = 8'(i); b = 8'h0F;
            tick();
            if (i == 15) chk("wrap_15", count_w, 15);
            if (i == 16) chk("wrap_0", count_w, 0);
            if (i == 17) chk("wrap_1", count_w, 1);
        end
        chk("wrap_count16", count, 17);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

Parametrised, registered successor to the single-bit two-input gate. Applies one of eight bitwise logic operations to two WIDTH-bit operands per transaction. Results pass through a 2-entry output buffer with valid/ready handshakes on both sides. The block sits between a stimulus producer and a result consumer, either of which may stall.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..64)
- CNT_W, 16, width of the completed-transaction counter

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer presents a, b, op this cycle
- in_ready  output  1  block can accept a transaction this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select, encoding below
- out_valid  output  1  y, y_all, y_any hold a valid result
- out_ready  input  1  consumer takes the result this cycle
- y  output  WIDTH  result at head of buffer
- y_all  output  1  AND-reduction of y (all ones)
- y_any  output  1  OR-reduction of y (any one)
- count  output  CNT_W  number of output handshakes completed, modulo 2^CNT_W

## Operation
- op encoding, bitwise per bit i:
  - 0: AND, a&b
  - 1: OR
  - 2: XOR
  - 3: NAND
  - 4: NOR
  - 5: XNOR
  - 6: NOT a (b ignored)
  - 7: BUF a (b ignored)
- Accept: in_valid && in_ready at a rising edge. The result is computed from the a, b, op values sampled at that edge and written to the buffer tail. Later changes to the inputs do not affect a stored entry.
- Emit: out_valid && out_ready at a rising edge. The head entry is removed and count increments by 1. count wraps from 2^CNT_W-1 to 0.
- Buffer: 2 entries, FIFO order, occupancy 0..2.
- in_ready = (occupancy < 2) && !rst. It depends only on registered state; there is no combinational path from out_ready.
- out_valid = (occupancy > 0).
- y shows the head entry. y_all and y_any are derived combinationally from y.
- Simultaneous accept and emit:
  - occupancy 1: occupancy stays 1 and the new result becomes the head.
  - occupancy 2: cannot occur, because in_ready = 0.
- Empty (occupancy 0): y, y_all and y_any hold their last values. Consumers must qualify them with out_valid.
- Reset asserted (any time, including mid-transfer):
  - all buffer contents are discarded and occupancy becomes 0 immediately
  - out_valid = 0, in_ready = 0, y = 0, y_all = 0, y_any = 0, count = 0
- After rst deasserts, in_ready = 1 in the first cycle.

## Timing
- Latency: 1 cycle. A result accepted at edge N has out_valid = 1 after edge N when the buffer was empty.
- Throughput: 1 transaction per cycle while out_ready is held high.
- Back-pressure with out_ready = 0: at most 2 transactions are accepted, then in_ready falls after the edge that fills the buffer.
- Release: one cycle of out_ready = 1 at occupancy 2 raises in_ready for the following cycle.
- Reset values: out_valid 0, in_ready 0 while rst = 1, y 0, y_all 0, y_any 0, count 0.

## Test plan
- Op sweep: WIDTH=8, a=8'hCA, b=8'h5F, out_ready=1, op 0..7 on consecutive cycles.
  - Expected y sequence: 4A, DF, 95, B5, 20, 6A, 35, CA, each one cycle after its accept.
  - count = 8 at the end.
- Reductions:
  - op=0, a=b=8'hFF -> y=FF, y_all=1, y_any=1.
  - op=0, a=8'hF0, b=8'h0F -> y=00, y_all=0, y_any=0.
- Back-pressure: out_ready=0 and in_valid=1 for 4 cycles with op=1, a=01/02/04/08, b=00.
  - Exactly 2 accepts; in_ready=0 from the third cycle.
  - Then set out_ready=1: y=01, then 02, then the accepted later values, in order, with none lost or duplicated.
- Simultaneous accept/emit at occupancy 1: occupancy stays 1 and y follows input order.
  - Stream 100 random transactions under random in_valid/out_ready patterns.
  - All 100 results must match the bitwise reference model in order, and count = 100.
- Counter wrap: CNT_W=4, 17 output handshakes -> count reads 15, then 0, then 1.
- Reset mid-operation: fill the buffer to 2, assert rst asynchronously between edges.
  - out_valid, y and count read 0 immediately.
  - in_ready=1 in the first cycle after release.
  - The next accepted transaction appears as the first result.
